// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - multi-channel button synchroniser, debouncer, edge/hold/repeat detector
module button_conditioner #(
    parameter int N_CH            = 3,
    parameter int ID_W            = 2,
    parameter int ACTIVE_LOW      = 0,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20,
    parameter int HOLD_CYCLES     = 50000000,
    parameter int REPEAT_CYCLES   = 10000000,
    parameter int HOLD_W          = 26
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic [N_CH-1:0] btn_in,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] press,
    output logic [N_CH-1:0] release_pulse,
    output logic [N_CH-1:0] held,
    output logic [N_CH-1:0] repeat_pulse,
    output logic            any_press,
    output logic [ID_W-1:0] press_id
);

    localparam logic [N_CH-1:0]   INV_MASK  = (ACTIVE_LOW != 0) ? {N_CH{1'b1}} : {N_CH{1'b0}};
    localparam logic [CNT_W-1:0]  DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  DB_ONE    = CNT_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] RPT_LAST  = HOLD_W'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

    localparam bit PARAMS_OK =
        (N_CH >= 1) && (N_CH <= 16) &&
        (DEBOUNCE_CYCLES >= 2) && (HOLD_CYCLES >= 1) && (REPEAT_CYCLES >= 0) &&
        ((64'd1 << ID_W)   >= 64'(N_CH)) &&
        ((64'd1 << CNT_W)  >  64'(DEBOUNCE_CYCLES)) &&
        ((64'd1 << HOLD_W) >  64'(HOLD_CYCLES)) &&
        ((64'd1 << HOLD_W) >  64'(REPEAT_CYCLES));

    logic [N_CH-1:0]   s0;
    logic [N_CH-1:0]   s1;
    logic [N_CH-1:0]   db_done;
    logic [CNT_W-1:0]  db_cnt   [N_CH];
    logic [HOLD_W-1:0] hold_cnt [N_CH];

    always @(posedge CLK) begin
        assert (PARAMS_OK) else $error("button_conditioner: illegal parameter combination");
    end

    // A channel's level flips when s1 has disagreed on this edge and the DEBOUNCE_CYCLES-1 before it
    always_comb begin
        db_done = '0;
        for (int i = 0; i < N_CH; i++) begin
            db_done[i] = (s1[i] != level[i]) && (db_cnt[i] == DB_LAST);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            s0            <= '0;
            s1            <= '0;
            level         <= '0;
            press         <= '0;
            release_pulse <= '0;
            held          <= '0;
            repeat_pulse  <= '0;
            for (int i = 0; i < N_CH; i++) begin
                db_cnt[i]   <= '0;
                hold_cnt[i] <= '0;
            end
        end else begin
            s0            <= btn_in ^ INV_MASK;
            s1            <= s0;
            press         <= '0;
            release_pulse <= '0;
            repeat_pulse  <= '0;
            for (int i = 0; i < N_CH; i++) begin
                if (s1[i] == level[i] || db_done[i]) begin
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_ONE;
                end

                if (db_done[i]) begin
                    level[i]         <= ~level[i];
                    press[i]         <= ~level[i];
                    release_pulse[i] <= level[i];
                end

                // After the hold threshold the same counter paces repeats; a falling edge wins over both
                if (!level[i] || db_done[i]) begin
                    hold_cnt[i] <= '0;
                    held[i]     <= 1'b0;
                end else if (!held[i]) begin
                    if (hold_cnt[i] == HOLD_LAST) begin
                        held[i]         <= 1'b1;
                        repeat_pulse[i] <= 1'b1;
                        hold_cnt[i]     <= '0;
                    end else begin
                        hold_cnt[i] <= hold_cnt[i] + HOLD_ONE;
                    end
                end else if (REPEAT_CYCLES > 0) begin
                    if (hold_cnt[i] == RPT_LAST) begin
                        repeat_pulse[i] <= 1'b1;
                        hold_cnt[i]     <= '0;
                    end else begin
                        hold_cnt[i] <= hold_cnt[i] + HOLD_ONE;
                    end
                end
            end
        end
    end

    always_comb begin
        any_press = |press;
        press_id  = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (press[i]) begin
                press_id = ID_W'(i);
            end
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - scoreboard bench for button_conditioner, active-high and active-low instances
module tb_button_conditioner;

    typedef struct {
        int         cyc;
        logic [2:0] p;
        logic [2:0] r;
        logic [2:0] rp;
        logic [2:0] h;
        logic       an;
        logic [1:0] id;
    } exp_t;

    logic       clk;
    logic       rst_a, rst_b;
    logic [2:0] btn_a, btn_b;
    logic [2:0] level_a, press_a, rel_a, held_a, rpt_a;
    logic [2:0] level_b, press_b, rel_b, held_b, rpt_b;
    logic       any_a, any_b;
    logic [1:0] id_a, id_b;

    int   cyc    = 0;
    int   tests  = 0;
    int   failed = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    exp_t e_a, e_b;

    button_conditioner #(
        .N_CH(3), .ID_W(2), .ACTIVE_LOW(0), .DEBOUNCE_CYCLES(4), .CNT_W(4),
        .HOLD_CYCLES(20), .REPEAT_CYCLES(8), .HOLD_W(6)
    ) dut_a (
        .CLK(clk), .RESET(rst_a), .btn_in(btn_a), .level(level_a), .press(press_a),
        .release_pulse(rel_a), .held(held_a), .repeat_pulse(rpt_a),
        .any_press(any_a), .press_id(id_a)
    );

    button_conditioner #(
        .N_CH(3), .ID_W(2), .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(4), .CNT_W(4),
        .HOLD_CYCLES(20), .REPEAT_CYCLES(8), .HOLD_W(6)
    ) dut_b (
        .CLK(clk), .RESET(rst_b), .btn_in(btn_b), .level(level_b), .press(press_b),
        .release_pulse(rel_b), .held(held_b), .repeat_pulse(rpt_b),
        .any_press(any_b), .press_id(id_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic score(input string tag, input exp_t e, input logic [2:0] p, input logic [2:0] r,
                         input logic [2:0] rp, input logic [2:0] h, input logic an, input logic [1:0] id);
        check({tag, " cycle"},     cyc, e.cyc);
        check({tag, " press"},     p,   e.p);
        check({tag, " release"},   r,   e.r);
        check({tag, " repeat"},    rp,  e.rp);
        check({tag, " held"},      h,   e.h);
        check({tag, " any_press"}, an,  e.an);
        check({tag, " press_id"},  id,  e.id);
    endtask

    task automatic push_a(input int cy, input logic [2:0] p, input logic [2:0] r, input logic [2:0] rp,
                          input logic [2:0] h, input logic an, input logic [1:0] id);
        exp_t e;
        e = '{cyc: cy, p: p, r: r, rp: rp, h: h, an: an, id: id};
        q_a.push_back(e);
    endtask

    task automatic push_b(input int cy, input logic [2:0] p, input logic [2:0] r, input logic [2:0] rp,
                          input logic [2:0] h, input logic an, input logic [1:0] id);
        exp_t e;
        e = '{cyc: cy, p: p, r: r, rp: rp, h: h, an: an, id: id};
        q_b.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if ((press_a | rel_a | rpt_a) != 3'b000) begin
            if (q_a.size() == 0) begin
                check("A unexpected strobe", {23'd0, press_a, rel_a, rpt_a}, 32'd0);
            end else begin
                e_a = q_a.pop_front();
                score("A", e_a, press_a, rel_a, rpt_a, held_a, any_a, id_a);
            end
        end
        if ((press_b | rel_b | rpt_b) != 3'b000) begin
            if (q_b.size() == 0) begin
                check("B unexpected strobe", {23'd0, press_b, rel_b, rpt_b}, 32'd0);
            end else begin
                e_b = q_b.pop_front();
                score("B", e_b, press_b, rel_b, rpt_b, held_b, any_b, id_b);
            end
        end
    end

    initial begin
        int c;
        rst_a = 1'b1;
        rst_b = 1'b1;
        btn_a = 3'b000;
        btn_b = 3'b111;
        tick(3);
        check("A reset outputs", {level_a, press_a, rel_a, held_a, rpt_a, any_a, id_a}, 32'd0);
        check("B reset outputs", {level_b, press_b, rel_b, held_b, rpt_b, any_b, id_b}, 32'd0);
        rst_a = 1'b0;
        tick(2);

        // clean press, hold threshold, repeats, release coinciding with a repeat slot
        c = cyc;
        btn_a[0] = 1'b1;
        push_a(c + 6,  3'b001, 3'b000, 3'b000, 3'b000, 1'b1, 2'd0);
        push_a(c + 26, 3'b000, 3'b000, 3'b001, 3'b001, 1'b0, 2'd0);
        push_a(c + 34, 3'b000, 3'b000, 3'b001, 3'b001, 1'b0, 2'd0);
        push_a(c + 42, 3'b000, 3'b000, 3'b001, 3'b001, 1'b0, 2'd0);
        push_a(c + 50, 3'b000, 3'b001, 3'b000, 3'b000, 1'b0, 2'd0);
        tick(5);
        check("level0 before debounce", level_a, 3'b000);
        tick(1);
        check("level0 after debounce", level_a, 3'b001);
        tick(19);
        check("held0 before threshold", held_a, 3'b000);
        tick(1);
        check("held0 at threshold", held_a, 3'b001);
        tick(18);
        btn_a[0] = 1'b0;
        tick(5);
        check("held0 before release", held_a, 3'b001);
        tick(1);
        check("level0 after release", level_a, 3'b000);
        tick(10);

        // bounce: three high samples, one low, then steady
        c = cyc;
        btn_a[0] = 1'b1;
        tick(3);
        btn_a[0] = 1'b0;
        tick(1);
        btn_a[0] = 1'b1;
        push_a(c + 10, 3'b001, 3'b000, 3'b000, 3'b000, 1'b1, 2'd0);
        tick(5);
        check("bounce no early level", level_a, 3'b000);
        tick(7);
        btn_a[0] = 1'b0;
        push_a(c + 22, 3'b000, 3'b001, 3'b000, 3'b000, 1'b0, 2'd0);
        tick(16);

        // simultaneous presses, then release on one channel with press on another
        c = cyc;
        btn_a = 3'b110;
        push_a(c + 6,  3'b110, 3'b000, 3'b000, 3'b000, 1'b1, 2'd1);
        tick(10);
        btn_a = 3'b101;
        push_a(c + 16, 3'b001, 3'b010, 3'b000, 3'b000, 1'b1, 2'd0);
        tick(8);
        btn_a = 3'b000;
        push_a(c + 24, 3'b000, 3'b101, 3'b000, 3'b000, 1'b0, 2'd0);
        tick(16);

        // reset while held; button stays down and is re-detected
        c = cyc;
        btn_a[0] = 1'b1;
        push_a(c + 6,  3'b001, 3'b000, 3'b000, 3'b000, 1'b1, 2'd0);
        push_a(c + 26, 3'b000, 3'b000, 3'b001, 3'b001, 1'b0, 2'd0);
        tick(27);
        check("held0 before reset", held_a, 3'b001);
        tick(1);
        rst_a = 1'b1;
        tick(1);
        rst_a = 1'b0;
        check("A outputs after mid-hold reset", {level_a, press_a, rel_a, held_a, rpt_a, any_a, id_a}, 32'd0);
        push_a(c + 35, 3'b001, 3'b000, 3'b000, 3'b000, 1'b1, 2'd0);
        tick(5);
        check("level0 not yet re-detected", level_a, 3'b000);
        tick(6);
        btn_a[0] = 1'b0;
        push_a(c + 46, 3'b000, 3'b001, 3'b000, 3'b000, 1'b0, 2'd0);
        tick(10);

        // active-low instance: idle-high pins must stay quiet
        rst_b = 1'b0;
        tick(12);
        check("B idle level", level_b, 3'b000);
        c = cyc;
        btn_b[2] = 1'b0;
        push_b(c + 6,  3'b100, 3'b000, 3'b000, 3'b000, 1'b1, 2'd2);
        tick(6);
        check("B level2 pressed", level_b, 3'b100);
        tick(4);
        btn_b[2] = 1'b1;
        push_b(c + 16, 3'b000, 3'b100, 3'b000, 3'b000, 1'b0, 2'd0);
        tick(12);
        check("B level2 released", level_b, 3'b000);

        check("A expected events all seen", q_a.size(), 32'd0);
        check("B expected events all seen", q_b.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
